// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared register offsets, CTRL bit positions and the timer
// run-state type for the APB timer slave.
package apb_timer_pkg;

  // Byte offsets within the slot; only PADDR[7:2] take part in decode.
  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_LOAD     = 8'h04;
  localparam logic [7:0] OFS_COUNT    = 8'h08;
  localparam logic [7:0] OFS_STATUS   = 8'h0C;
  localparam logic [7:0] OFS_PRESCALE = 8'h10;

  // CTRL register fields
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_RELOAD_EN = 1;
  localparam int unsigned CTRL_IRQ_EN    = 2;
  localparam int unsigned CTRL_BITS      = 3;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/apb_timer_counter.sv
// apb_timer_counter: prescaler, 32-bit down-counter and expiry detection.
// Ports:
//   PCLK, PRESETn  clock / asynchronous active-low reset
//   en             enable for this cycle (CTRL.EN, or the value being written)
//   en_wr          a CTRL write commits this edge (overrides one-shot stop)
//   reload_en      reload COUNT from load_val on expiry instead of stopping
//   load_val       reload / load value
//   load_strobe    LOAD write: COUNT <= load_val, prescaler cleared
//   prescale       tick every prescale+1 running cycles
//   count          current count
//   expire         pulse: tick while COUNT==0
//   en_clear       pulse: one-shot expiry, caller clears CTRL.EN
module apb_timer_counter
  import apb_timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 en,
  input  logic                 en_wr,
  input  logic                 reload_en,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 load_strobe,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 expire,
  output logic                 en_clear
);

  tmr_state_t           state_q, state_d;
  logic [PRE_WIDTH-1:0] pre_cnt;
  logic                 running;
  logic                 tick;

  // Counting needs both the registered run state and the enable seen this
  // cycle, so a CTRL write of EN=0 suppresses the tick on its own edge.
  assign running  = (state_q == RUNNING) && en;
  assign tick     = running && (pre_cnt == prescale);
  assign expire   = tick && (count == '0);
  assign en_clear = expire && !reload_en;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= STOPPED;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOPPED: if (en) state_d = RUNNING;
      // A coincident CTRL write decides EN, beating the one-shot stop.
      RUNNING: if (!en || (en_clear && !en_wr)) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pre_cnt <= '0;
      count   <= '0;
    end else if (load_strobe) begin
      pre_cnt <= '0;
      count   <= load_val;
    end else if (tick) begin
      pre_cnt <= '0;
      if (count != '0)    count <= count - CNT_WIDTH'(1);
      else if (reload_en) count <= load_val;
    end else if (running) begin
      pre_cnt <= pre_cnt + PRE_WIDTH'(1);
    end else begin
      pre_cnt <= '0;
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB slave holding a prescaled down-counting timer with
// a level interrupt and programmable PREADY wait states.
// Ports:
//   PCLK, PRESETn  APB clock / asynchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request
//   PREADY         low for WAIT_STATES cycles of every ACCESS phase
//   PRDATA         register read data during read ACCESS, else 0
//   IRQ            STATUS.EXPIRED & CTRL.IRQ_EN
// Map: 0x00 CTRL, 0x04 LOAD, 0x08 COUNT (RO), 0x0C STATUS (W1C), 0x10 PRESCALE.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PRE_WIDTH   = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  IRQ
);

  logic [3:0]            wait_cnt;
  logic                  setup, access, wr;
  logic [7:0]            ofs;
  logic                  ctrl_wr, load_wr, status_wr, pre_wr;
  logic [CTRL_BITS-1:0]  ctrl_q;
  logic [DATA_WIDTH-1:0] load_q;
  logic [PRE_WIDTH-1:0]  prescale_q;
  logic                  expired_q;
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  en_now;
  logic                  expire, en_clear;
  logic                  unused_addr;

  assign unused_addr = ^{PADDR[ADDR_WIDTH-1:8], PADDR[1:0]};

  assign setup  = PSEL && !PENABLE;
  assign access = PSEL && PENABLE;
  assign PREADY = access ? (wait_cnt == '0) : 1'b1;
  assign wr     = access && PREADY && PWRITE;
  assign ofs    = {PADDR[7:2], 2'b00};

  assign ctrl_wr   = wr && (ofs == OFS_CTRL);
  assign load_wr   = wr && (ofs == OFS_LOAD);
  assign status_wr = wr && (ofs == OFS_STATUS);
  assign pre_wr    = wr && (ofs == OFS_PRESCALE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                         wait_cnt <= '0;
    else if (setup)                       wait_cnt <= 4'(WAIT_STATES);
    else if (access && wait_cnt != '0)    wait_cnt <= wait_cnt - 4'd1;
  end

  // The counter sees the enable being written this edge so that EN=0
  // blocks a coincident tick; LOAD data is forwarded the same way.
  assign en_now   = ctrl_wr ? PWDATA[CTRL_EN] : ctrl_q[CTRL_EN];
  assign load_val = load_wr ? PWDATA : load_q;

  apb_timer_counter #(
    .CNT_WIDTH(DATA_WIDTH),
    .PRE_WIDTH(PRE_WIDTH)
  ) u_counter (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .en         (en_now),
    .en_wr      (ctrl_wr),
    .reload_en  (ctrl_q[CTRL_RELOAD_EN]),
    .load_val   (load_val),
    .load_strobe(load_wr),
    .prescale   (prescale_q),
    .count      (count),
    .expire     (expire),
    .en_clear   (en_clear)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q     <= '0;
      load_q     <= '0;
      prescale_q <= '0;
      expired_q  <= 1'b0;
    end else begin
      if (ctrl_wr)       ctrl_q <= PWDATA[CTRL_BITS-1:0];
      else if (en_clear) ctrl_q[CTRL_EN] <= 1'b0;
      if (load_wr) load_q <= PWDATA;
      if (pre_wr)  prescale_q <= PWDATA[PRE_WIDTH-1:0];
      // Expiry outranks a coincident write-1-to-clear.
      if (expire)                             expired_q <= 1'b1;
      else if (status_wr && PWDATA[0])        expired_q <= 1'b0;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      unique case (ofs)
        OFS_CTRL:     PRDATA = {{(DATA_WIDTH-CTRL_BITS){1'b0}}, ctrl_q};
        OFS_LOAD:     PRDATA = load_q;
        OFS_COUNT:    PRDATA = count;
        OFS_STATUS:   PRDATA = {{(DATA_WIDTH-1){1'b0}}, expired_q};
        OFS_PRESCALE: PRDATA = {{(DATA_WIDTH-PRE_WIDTH){1'b0}}, prescale_q};
        default:      PRDATA = '0;
      endcase
    end
  end

  assign IRQ = expired_q && ctrl_q[CTRL_IRQ_EN];

endmodule
